// File: rtl/rr_sel_sequencer.sv
// rr_sel_sequencer: registered round-robin arbiter feeding the en/sel pins of
// a 3-to-8 one-hot decoder. Each grant lasts at most DWELL cycles. The granted
// channel c is driven as sel = 7 - c, so decoder output d[c] is the live line.
// Optional macro GUARD_EN: when defined, a one-cycle GAP with en=0 separates
// grants so that sel never changes while en is high. When it is undefined,
// grants run back to back and sel may change while en=1.
module rr_sel_sequencer #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic       en,
  output logic [2:0] sel,
  output logic [2:0] grant_ch,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [2:0] ptr, ptr_n;
  logic [2:0] gch_n;
  logic [2:0] sel_n;
  logic       en_n, busy_n;
  logic [2:0] winner;
  logic       any_req;
  logic       release_g;

  // Round-robin pick: scan ptr+1 .. ptr+8 (mod 8), first set bit wins, so the
  // channel at ptr itself gets the lowest priority.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] pick;
    logic [2:0] c;
    logic       found;
    pick  = p;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      c = p + 3'(i);
      if (!found && r[c]) begin
        pick  = c;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign any_req   = |req;
  assign winner    = rr_pick(req, ptr);
  assign release_g = done | ~req[grant_ch] | (cnt == DWELL_LAST);

  // Next-state and next-output logic; registered outputs derive from state_n
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ptr_n   = ptr;
    gch_n   = grant_ch;
    case (state)
      IDLE, GAP: begin
        if (any_req) begin
          state_n = GRANT;
          gch_n   = winner;
          ptr_n   = winner;
          cnt_n   = 8'd0;
        end else begin
          state_n = IDLE;
        end
      end
      GRANT: begin
        if (!release_g) begin
          cnt_n = cnt + 8'd1;
        end else begin
`ifdef GUARD_EN
          state_n = GAP;
`else
          if (any_req) begin
            state_n = GRANT;
            gch_n   = winner;
            ptr_n   = winner;
            cnt_n   = 8'd0;
          end else begin
            state_n = IDLE;
          end
`endif
        end
      end
      default: state_n = IDLE;
    endcase
    sel_n  = ~gch_n;
    en_n   = (state_n == GRANT);
    busy_n = (state_n != IDLE);
  end

  // State and output registers; reset wins over every other input
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      ptr      <= 3'd7;
      grant_ch <= 3'd0;
      sel      <= 3'b111;
      en       <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      ptr      <= ptr_n;
      grant_ch <= gch_n;
      sel      <= sel_n;
      en       <= en_n;
      busy     <= busy_n;
    end
  end

endmodule

// File: tb/tb_rr_sel_sequencer.sv
// Self-checking bench for rr_sel_sequencer (DWELL=4). Expected outputs come
// from a cycle model pushed into a queue before each edge and popped after it.
// Honours GUARD_EN the same way the design does.
module tb_rr_sel_sequencer;

  localparam int DWELL = 4;
`ifdef GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic       en;
  logic [2:0] sel;
  logic [2:0] grant_ch;
  logic       busy;

  rr_sel_sequencer #(.DWELL(DWELL)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .en       (en),
    .sel      (sel),
    .grant_ch (grant_ch),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       en;
    logic [2:0] sel;
    logic [2:0] gch;
    logic       busy;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int errors = 0;

  // reference model state: 0 idle, 1 grant, 2 gap
  int         m_st;
  logic [2:0] m_gch;
  int         m_cnt;
  int         m_ptr;

  bit         track;
  logic       prev_en;
  logic [2:0] prev_sel;
  logic [2:0] grants[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_edge(input logic r_rst, input logic [7:0] r, input logic d);
    bit arb;
    int win;
    int c;
    if (r_rst) begin
      m_st = 0; m_gch = 3'd0; m_cnt = 0; m_ptr = 7;
      return;
    end
    arb = 1'b0;
    if (m_st != 1) begin
      arb = 1'b1;
    end else if (d || !r[m_gch] || (m_cnt == DWELL - 1)) begin
      if (GUARD) m_st = 2;
      else       arb  = 1'b1;
    end else begin
      m_cnt++;
    end
    if (arb) begin
      win = -1;
      for (int k = 1; k <= 8; k++) begin
        c = (m_ptr + k) % 8;
        if (win < 0 && r[c]) win = c;
      end
      if (win >= 0) begin
        m_st = 1; m_gch = 3'(win); m_ptr = win; m_cnt = 0;
      end else begin
        m_st = 0;
      end
    end
  endtask

  task automatic step(input logic r_rst, input logic [7:0] r, input logic d);
    exp_t e;
    rst  = r_rst;
    req  = r;
    done = d;
    model_edge(r_rst, r, d);
    e.en   = (m_st == 1);
    e.sel  = 3'd7 - m_gch;
    e.gch  = m_gch;
    e.busy = (m_st != 0);
    q.push_back(e);
    @(posedge clk);
    #1;
    chk("queue_nonempty", 8'(q.size() > 0), 8'd1);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("sb_en",   8'(en),       8'(e.en));
      chk("sb_sel",  8'(sel),      8'(e.sel));
      chk("sb_gch",  8'(grant_ch), 8'(e.gch));
      chk("sb_busy", 8'(busy),     8'(e.busy));
    end
    if (track && en && (!prev_en || sel != prev_sel)) grants.push_back(sel);
    prev_en  = en;
    prev_sel = sel;
  endtask

  logic [2:0] rr_exp [4];
  logic [7:0] rq;

  initial begin
    rst = 1'b1; req = 8'h00; done = 1'b0;
    track = 1'b0; prev_en = 1'b0; prev_sel = 3'd7;
    m_st = 0; m_gch = 3'd0; m_cnt = 0; m_ptr = 7;
    rr_exp[0] = 3'd7; rr_exp[1] = 3'd6; rr_exp[2] = 3'd0; rr_exp[3] = 3'd7;

    // reset with all requests high
    step(1'b1, 8'hFF, 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    chk("rst_en",   8'(en),       8'd0);
    chk("rst_sel",  8'(sel),      8'd7);
    chk("rst_gch",  8'(grant_ch), 8'd0);
    chk("rst_busy", 8'(busy),     8'd0);
    step(1'b0, 8'hFF, 1'b0);
    chk("first_en",  8'(en),       8'd1);
    chk("first_sel", 8'(sel),      8'd7);
    chk("first_gch", 8'(grant_ch), 8'd0);

    // dwell with a single requester on channel 2
    step(1'b1, 8'h04, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h04, 1'b0);
      chk("dwell_en",  8'(en),  8'd1);
      chk("dwell_sel", 8'(sel), 8'd5);
    end
    step(1'b0, 8'h04, 1'b0);
    chk("dwell_gap_en",   8'(en),   GUARD ? 8'd0 : 8'd1);
    chk("dwell_gap_busy", 8'(busy), 8'd1);
    step(1'b0, 8'h04, 1'b0);
    chk("regrant_en",  8'(en),       8'd1);
    chk("regrant_gch", 8'(grant_ch), 8'd2);

    // round-robin order from reset: ch0, ch1, ch7, ch0
    step(1'b1, 8'h83, 1'b0);
    grants.delete();
    prev_en = 1'b0;
    track = 1'b1;
    for (int i = 0; i < 16; i++) step(1'b0, 8'h83, 1'b0);
    track = 1'b0;
    chk("rr_count", 8'(grants.size() >= 4), 8'd1);
    for (int i = 0; i < 4; i++) begin
      if (i < grants.size()) chk("rr_sel", 8'(grants[i]), 8'(rr_exp[i]));
      else                   chk("rr_sel_missing", 8'(i), 8'd255);
    end

    // early release with done on the 2nd grant cycle of ch5
    step(1'b1, 8'h20, 1'b0);
    step(1'b0, 8'h20, 1'b0);
    step(1'b0, 8'h20, 1'b0);
    chk("early_done_en_last", 8'(en), 8'd1);
    step(1'b0, 8'h20, 1'b1);
    chk("early_done_en", 8'(en), GUARD ? 8'd0 : 8'd1);

    // early release by dropping req[5] on the 2nd grant cycle
    step(1'b1, 8'h20, 1'b0);
    step(1'b0, 8'h20, 1'b0);
    step(1'b0, 8'h20, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("early_drop_en",   8'(en),   8'd0);
    chk("early_drop_busy", 8'(busy), GUARD ? 8'd1 : 8'd0);
    step(1'b0, 8'h00, 1'b0);
    chk("idle_busy",    8'(busy),     8'd0);
    chk("idle_gch_hold", 8'(grant_ch), 8'd5);

    // reset mid-grant, arbitration restarts from ch0
    step(1'b0, 8'h10, 1'b0);
    step(1'b0, 8'h10, 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    chk("midrst_en",   8'(en),   8'd0);
    chk("midrst_busy", 8'(busy), 8'd0);
    step(1'b0, 8'hFF, 1'b0);
    chk("midrst_regrant", 8'(grant_ch), 8'd0);

    // back-to-back channels 0/1
    step(1'b1, 8'h03, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h03, 1'b0);

    // random traffic checked against the model
    for (int i = 0; i < 300; i++) begin
      rq = 8'($urandom) & 8'($urandom) & 8'($urandom);
      step(($urandom_range(0, 49) == 0), rq, ($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_sel_sequencer.md
Name: rr_sel_sequencer

Overview:
- Registered round-robin arbiter driving the en/sel inputs of the 3-to-8 one-hot output decoder (Decoder2), one stage upstream of it.
- Arbitrates 8 request lines, holds each grant for a bounded dwell time, and inserts a one-cycle guard gap between grants.
- Encodes the granted channel c as sel = 7 - c, so decoder output d[c] is the active line.

Parameters:
- DWELL, 4: maximum en-high cycles per grant; legal range 1..255 (8-bit counter).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- req  in  8  per-channel request, level-sensitive, req[c] for channel c
- done  in  1  early release of the current grant; ignored outside GRANT
- en  out  1  decoder enable, registered
- sel  out  3  decoder select, registered; sel = 7 - grant_ch
- grant_ch  out  3  granted channel number (equals ~sel), registered
- busy  out  1  high in GRANT and GAP states

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, en=0, sel=3'b111, grant_ch=0, busy=0, dwell count=0, round-robin pointer ptr=7. Reset mid-grant drops en on the next edge. Reset overrides every other input.
- States: IDLE, GRANT, GAP.
- Arbitration is done in IDLE and GAP, or in GRANT on release when GUARD_EN is not defined. It uses req sampled that cycle. Search order is ptr+1, ptr+2, ... mod 8. The first set bit wins, so ptr's own channel has the lowest priority.
- IDLE:
  - req==0: stay in IDLE, en=0.
  - Otherwise: next edge goes to GRANT, en=1, grant_ch=winner, sel=7-winner, ptr=winner, cnt=0.
- GRANT: en=1 and sel stable. The release condition is evaluated each cycle: done | ~req[grant_ch] | (cnt==DWELL-1).
  - No release: cnt increments.
  - Release: next edge goes to GAP (en=0, sel/grant_ch held).
  - en is high for exactly DWELL cycles when no early release occurs.
  - On early release, the cycle in which done or the dropped req is sampled is the last en-high cycle.
- GAP: exactly one cycle, en=0, busy=1.
  - If req!=0 at that cycle: arbitrate and go to GRANT.
  - Otherwise: go to IDLE. Going to IDLE leaves sel/grant_ch holding their last value.
- Single requester: the same channel is re-granted after each GAP.
- DWELL=1: every grant lasts one cycle, giving the sequence GRANT, GAP, GRANT...
- A request raised during GAP is eligible in that same GAP cycle.
- Latency from req rising in IDLE to en=1 is 1 cycle.
- en and sel never change in the same edge in a way that produces a glitch-visible overlap: the GAP cycle guarantees en=0 across a channel change.

Optional Feature:
- Macro GUARD_EN.
- Defined: the GAP state exists exactly as described above. This is the required production build.
- Not defined: the GAP state is removed. On release in GRANT, the block arbitrates in the same cycle:
  - req!=0: next edge stays in GRANT with the new winner, cnt=0, and en held at 1. sel changes while en=1 (back-to-back grants).
  - req==0: go to IDLE, en=0.
  - busy equals en.

Test Plan:
- Reset: hold rst=1 two cycles with req=8'hFF -> en=0, sel=3'b111, grant_ch=0, busy=0. Release rst -> next edge grant_ch=0, sel=3'b111, en=1.
- Dwell: DWELL=4, req=8'b0000_0100 held -> en high 4 cycles with sel=3'b101, then 1 cycle en=0, then a re-grant of channel 2.
- Round-robin: req=8'b1000_0011 held, starting from reset -> grant order ch0, ch1, ch7, ch0, with sel=7,6,0,7 and a GAP between each.
- Early release: in the 2nd GRANT cycle of ch5, pulse done=1 -> en=1 that cycle, en=0 next cycle. Dropping req[5] instead gives the same timing.
- Reset mid-grant: assert rst in the 2nd GRANT cycle -> next edge en=0, busy=0, and the following arbitration restarts from ch0 (ptr=7).
- GUARD_EN undefined: req=8'b0000_0011, DWELL=2 -> en stays 1 continuously while sel alternates 7,7,6,6,7,7.
